// File: rtl/opora_pkg.sv
// opora_pkg: shared constants, error codes and FSM encoding for the opora loader.
`default_nettype none
package opora_pkg;

  localparam int NUM_OPORA = 200;
  localparam logic [15:0] MAGIC = 16'h4F50;
  localparam int GAP_CYC = 2;

  localparam int FRAME_LEN = 4 + 2 * NUM_OPORA + 2;
  localparam int ADDR_W = $clog2(NUM_OPORA);
  localparam int POS_W = $clog2(FRAME_LEN);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [7:0] NUM_BYTE = 8'(NUM_OPORA);
  localparam logic [POS_W-1:0] POS_CSUM = POS_W'(4 + 2 * NUM_OPORA);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);

  localparam logic [1:0] ERR_HDR = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DRAIN   = 3'd4,
    REPLAY  = 3'd5,
    GAP     = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/opora_sample_ram.sv
// opora_sample_ram: NUM_OPORA x 16 sample buffer, one write port, one registered read port.
`default_nettype none
module opora_sample_ram
  import opora_pkg::*;
(
  input  logic              clke,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [NUM_OPORA];
  logic [15:0] r_rdata;

  always_ff @(posedge clke) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/opora_loader.sv
// opora_loader: validates opora frames from the Ethernet RX path, buffers the samples
// and replays them as an opora_en/OPORA strobe burst only after the checksum passes.
`default_nettype none
module opora_loader
  import opora_pkg::*;
(
  input  logic        clke,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic [7:0]  rx_data,
  output logic        opora_en,
  output logic [15:0] OPORA,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  output logic [1:0]  err_code,
  output logic [7:0]  load_cnt
);

  state_t            r_state, w_state_nxt;
  logic [POS_W-1:0]  r_pos, w_pos_nxt, w_p;
  logic [7:0]        r_prev;
  logic [15:0]       r_acc, w_acc_nxt, w_word;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt, r_raddr, w_raddr_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic              w_in_frame, w_take, w_we, w_re, w_err, w_hdr_bad, w_last_rd;
  logic [1:0]        w_code;
  logic              r_en, r_last, r_done, r_err;
  logic [1:0]        r_code;
  logic [7:0]        r_cnt;
  logic [15:0]       w_rdata;

  assign w_in_frame = (r_state == HDR) || (r_state == PAYLOAD) || (r_state == CSUM);
  assign w_take     = rx_valid && (w_in_frame || (r_state == IDLE && rx_sof));
  // A sof byte always restarts byte numbering at B0.
  assign w_p        = rx_sof ? '0 : r_pos;
  assign w_word     = {r_prev, rx_data};
  assign w_last_rd  = (r_raddr == ADDR_W'(NUM_OPORA - 1));
  assign w_hdr_bad  = (w_p == POS_W'(0) && rx_data != MAGIC[15:8]) ||
                      (w_p == POS_W'(1) && rx_data != MAGIC[7:0])  ||
                      (w_p == POS_W'(2) && rx_data != NUM_BYTE);

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_acc_nxt   = r_acc;
    w_waddr_nxt = r_waddr;
    w_raddr_nxt = r_raddr;
    w_gap_nxt   = r_gap;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_err       = 1'b0;
    w_code      = r_code;
    case (r_state)
      IDLE, HDR, PAYLOAD, CSUM: begin
        if (w_take) begin
          w_pos_nxt = w_p + POS_W'(1);
          if (rx_sof) begin
            w_acc_nxt   = '0;
            w_waddr_nxt = '0;
            if (w_in_frame) begin
              w_err  = 1'b1;
              w_code = ERR_LEN;
            end
          end
          if (w_pos_nxt < POS_W'(4))   w_state_nxt = HDR;
          else if (w_pos_nxt < POS_CSUM) w_state_nxt = PAYLOAD;
          else                           w_state_nxt = CSUM;
          // Odd payload positions carry the LSB byte that completes a sample.
          if (w_p >= POS_W'(4) && w_p < POS_CSUM && w_p[0]) begin
            w_we        = 1'b1;
            w_acc_nxt   = r_acc + w_word;
            w_waddr_nxt = r_waddr + ADDR_W'(1);
          end
          if (w_p == POS_LAST) begin
            w_pos_nxt = '0;
            if (!rx_eof) begin
              w_err       = 1'b1;
              w_code      = ERR_LEN;
              w_state_nxt = DRAIN;
            end else if (w_word != r_acc) begin
              w_err       = 1'b1;
              w_code      = ERR_CSUM;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = REPLAY;
            end
          end else if (rx_eof) begin
            w_pos_nxt   = '0;
            w_err       = 1'b1;
            w_code      = ERR_LEN;
            w_state_nxt = IDLE;
          end else if (w_hdr_bad) begin
            w_pos_nxt   = '0;
            w_err       = 1'b1;
            w_code      = ERR_HDR;
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rx_valid && rx_eof) w_state_nxt = IDLE;
      end
      REPLAY: begin
        w_re = 1'b1;
        if (w_last_rd) begin
          w_raddr_nxt = '0;
          w_state_nxt = GAP;
        end else begin
          w_raddr_nxt = r_raddr + ADDR_W'(1);
        end
      end
      GAP: begin
        if (r_gap == GAP_W'(GAP_CYC)) begin
          w_gap_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clke or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_prev  <= '0;
      r_acc   <= '0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_gap   <= '0;
      r_en    <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_acc   <= w_acc_nxt;
      r_waddr <= w_waddr_nxt;
      r_raddr <= w_raddr_nxt;
      r_gap   <= w_gap_nxt;
      if (w_take) r_prev <= rx_data;
      // Strobe flags align with the RAM's one-cycle read latency.
      r_en    <= (r_state == REPLAY);
      r_last  <= (r_state == REPLAY) && w_last_rd;
      r_done  <= r_last;
      if (r_last) r_cnt <= r_cnt + 8'd1;
      r_err   <= w_err;
      r_code  <= w_code;
    end
  end

  opora_sample_ram u_ram (
    .clke    (clke),
    .i_we    (w_we),
    .i_waddr (r_waddr),
    .i_wdata (w_word),
    .i_re    (w_re),
    .i_raddr (r_raddr),
    .o_rdata (w_rdata)
  );

  // RAM output has no reset, so gate it to keep OPORA at 0 outside strobes.
  assign opora_en  = r_en;
  assign OPORA     = r_en ? w_rdata : 16'h0000;
  assign busy      = (r_state == REPLAY) || (r_state == GAP);
  assign load_done = r_done;
  assign load_err  = r_err;
  assign err_code  = r_code;
  assign load_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_opora_loader.sv
// tb_opora_loader: randomized frame stimulus checked against a frame-level reference model.
`default_nettype none
module tb_opora_loader;

  localparam int NUM = 200;
  localparam int FLEN = 4 + 2 * NUM + 2;
  localparam logic [15:0] MAG = 16'h4F50;

  typedef logic [9:0] fw_t;  // {sof, eof, data}

  logic        clke = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        opora_en, busy, load_done, load_err;
  logic [15:0] OPORA;
  logic [1:0]  err_code;
  logic [7:0]  load_cnt;

  opora_loader dut (
    .clke(clke), .rst(rst), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_data(rx_data), .opora_en(opora_en), .OPORA(OPORA), .busy(busy),
    .load_done(load_done), .load_err(load_err), .err_code(err_code), .load_cnt(load_cnt)
  );

  always #5 clke = ~clke;

  int cyc = 0;
  always @(posedge clke) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  fw_t         fr[$];
  int          byte_cyc[$];
  logic [15:0] smp[NUM];
  logic [15:0] exp_q[$];

  // Monitor: records strobes, burst boundaries, done and error events.
  logic [15:0] got_q[$];
  int          bstart_q[$], bend_q[$], blen_q[$], done_q[$], errc_q[$];
  logic [1:0]  errcode_q[$];
  logic        prev_en = 1'b0;
  int          run = 0;

  always @(negedge clke) begin
    if (rst) begin
      prev_en = 1'b0;
      run = 0;
    end else begin
      if (opora_en) begin
        got_q.push_back(OPORA);
        if (!prev_en) bstart_q.push_back(cyc);
        run++;
      end else if (prev_en) begin
        bend_q.push_back(cyc - 1);
        blen_q.push_back(run);
        run = 0;
      end
      prev_en = opora_en;
      if (load_done) done_q.push_back(cyc);
      if (load_err) begin
        errc_q.push_back(cyc);
        errcode_q.push_back(err_code);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clke);
    #1;
  endtask

  task automatic rand_smp();
    for (int k = 0; k < NUM; k++) smp[k] = 16'($urandom);
  endtask

  task automatic push_exp();
    for (int k = 0; k < NUM; k++) exp_q.push_back(smp[k]);
  endtask

  task automatic build(input logic flip);
    logic [15:0] sum;
    logic [15:0] m;
    sum = 16'h0000;
    m = MAG;
    fr.delete();
    fr.push_back({2'b10, m[15:8]});
    fr.push_back({2'b00, m[7:0]});
    fr.push_back({2'b00, 8'(NUM)});
    fr.push_back({2'b00, 8'($urandom)});
    for (int k = 0; k < NUM; k++) begin
      sum = sum + smp[k];
      fr.push_back({2'b00, smp[k][15:8]});
      fr.push_back({2'b00, smp[k][7:0]});
    end
    sum = sum ^ {15'd0, flip};
    fr.push_back({2'b00, sum[15:8]});
    fr.push_back({2'b01, sum[7:0]});
  endtask

  task automatic fix_eof();
    foreach (fr[i]) fr[i][8] = 1'b0;
    fr[fr.size() - 1][8] = 1'b1;
  endtask

  // Reference model: outcome of a single frame (0 = accepted, else error code).
  function automatic int model_code();
    logic [15:0] sum;
    logic [15:0] m;
    logic [7:0]  d;
    int          n;
    sum = 16'h0000;
    m = MAG;
    n = fr.size();
    for (int i = 0; i < n; i++) begin
      d = fr[i][7:0];
      if (i == FLEN - 1) begin
        if (i != n - 1) return 2;
        return ({fr[i-1][7:0], d} == sum) ? 0 : 3;
      end
      if (i == n - 1) return 2;
      if (i == 0 && d != m[15:8]) return 1;
      if (i == 1 && d != m[7:0]) return 1;
      if (i == 2 && d != 8'(NUM)) return 1;
      if (i >= 4 && i < 4 + 2 * NUM && (i % 2) == 1) sum = sum + {fr[i-1][7:0], d};
    end
    return 2;
  endfunction

  task automatic send(input int pct);
    byte_cyc.delete();
    foreach (fr[i]) begin
      while (int'($urandom_range(99)) >= pct) begin
        @(posedge clke); #1;
        rx_valid = 1'b0;
        rx_sof = 1'($urandom_range(1));
        rx_eof = 1'($urandom_range(1));
        rx_data = 8'($urandom);
      end
      @(posedge clke); #1;
      {rx_sof, rx_eof, rx_data} = fr[i];
      rx_valid = 1'b1;
      byte_cyc.push_back(cyc);
    end
    @(posedge clke); #1;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clke);
    #1;
    checks++;
    if ({opora_en, OPORA, busy, load_done, load_err, err_code, load_cnt} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0b opora=%h busy=%0b done=%0b err=%0b code=%0d cnt=%0d, want all 0",
               opora_en, OPORA, busy, load_done, load_err, err_code, load_cnt);
    end
    rst = 1'b0;
    wait_cyc(3);
    checks++;
    if ({opora_en, busy, load_err, load_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got en=%0b busy=%0b err=%0b cnt=%0d, want 0", opora_en, busy, load_err, load_cnt);
    end
  endtask

  task automatic test_valid();
    int s0, b0, d0, e0, nbad;
    s0 = got_q.size(); b0 = bstart_q.size(); d0 = done_q.size(); e0 = errc_q.size();
    for (int k = 0; k < NUM; k++) smp[k] = 16'(3 * k - 300);
    build(1'b0);
    checks++;
    if (model_code() != 0) begin errors++; $display("FAIL valid_model: got %0d want 0", model_code()); end
    send(100);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL valid_busy: got %0b want 1", busy); end
    wait_cyc(260);
    exp_cnt++;
    checks++;
    if (blen_q.size() - b0 != 1 || got_q.size() - s0 != NUM) begin
      errors++;
      $display("FAIL valid_burst: got %0d bursts %0d strobes, want 1 burst %0d strobes", blen_q.size() - b0, got_q.size() - s0, NUM);
    end else begin
      checks++;
      if (blen_q[b0] != NUM) begin errors++; $display("FAIL valid_len: got %0d want %0d", blen_q[b0], NUM); end
      checks++;
      if (got_q[s0] !== 16'hFED4) begin errors++; $display("FAIL valid_first: got %h want fed4", got_q[s0]); end
      checks++;
      if (got_q[s0 + NUM - 1] !== 16'h0129) begin errors++; $display("FAIL valid_last: got %h want 0129", got_q[s0 + NUM - 1]); end
      nbad = 0;
      for (int k = 0; k < NUM; k++) if (got_q[s0 + k] !== smp[k]) nbad++;
      checks++;
      if (nbad != 0) begin errors++; $display("FAIL valid_values: got %0d wrong samples want 0", nbad); end
      checks++;
      if (bstart_q[b0] - byte_cyc[FLEN - 1] != 2) begin
        errors++; $display("FAIL valid_latency: got %0d want 2", bstart_q[b0] - byte_cyc[FLEN - 1]);
      end
    end
    checks++;
    if (done_q.size() - d0 != 1 || bend_q.size() <= b0) begin
      errors++; $display("FAIL valid_done_count: got %0d want 1", done_q.size() - d0);
    end else begin
      checks++;
      if (done_q[d0] - bend_q[b0] != 1) begin
        errors++; $display("FAIL valid_done_timing: got %0d want 1", done_q[d0] - bend_q[b0]);
      end
    end
    checks++;
    if (load_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL valid_cnt: got %0d want %0d", load_cnt, exp_cnt); end
    checks++;
    if (errc_q.size() != e0) begin errors++; $display("FAIL valid_no_err: got %0d want 0", errc_q.size() - e0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL valid_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_csum_err();
    int s0, e0;
    s0 = got_q.size(); e0 = errc_q.size();
    build(1'b1);
    send(100);
    wait_cyc(260);
    checks++;
    if (errc_q.size() - e0 != 1) begin
      errors++; $display("FAIL csum_err_count: got %0d want 1", errc_q.size() - e0);
    end else begin
      checks++;
      if (errcode_q[e0] !== 2'(model_code()) || err_code !== 2'd3) begin
        errors++; $display("FAIL csum_code: got %0d want 3 (model %0d)", errcode_q[e0], model_code());
      end
      checks++;
      if (errc_q[e0] != byte_cyc[FLEN - 1] + 1) begin
        errors++; $display("FAIL csum_err_timing: got %0d want %0d", errc_q[e0], byte_cyc[FLEN - 1] + 1);
      end
    end
    checks++;
    if (got_q.size() != s0) begin errors++; $display("FAIL csum_strobes: got %0d want 0", got_q.size() - s0); end
    checks++;
    if (load_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL csum_cnt: got %0d want %0d", load_cnt, exp_cnt); end
  endtask

  task automatic test_hdr_err();
    int s0, e0, pos;
    for (int t = 0; t < 2; t++) begin
      s0 = got_q.size(); e0 = errc_q.size();
      rand_smp();
      build(1'b0);
      pos = (t == 0) ? 0 : 2;
      fr[pos][7:0] = (t == 0) ? 8'h4E : 8'd199;
      send(100);
      wait_cyc(10);
      checks++;
      if (errc_q.size() - e0 != 1) begin
        errors++; $display("FAIL hdr_err_count[%0d]: got %0d want 1", t, errc_q.size() - e0);
      end else begin
        checks++;
        if (errcode_q[e0] !== 2'(model_code()) || errcode_q[e0] !== 2'd1) begin
          errors++; $display("FAIL hdr_code[%0d]: got %0d want 1", t, errcode_q[e0]);
        end
        checks++;
        if (errc_q[e0] != byte_cyc[pos] + 1) begin
          errors++; $display("FAIL hdr_err_timing[%0d]: got %0d want %0d", t, errc_q[e0], byte_cyc[pos] + 1);
        end
      end
      checks++;
      if (got_q.size() != s0 || busy !== 1'b0) begin
        errors++; $display("FAIL hdr_strobes[%0d]: got %0d strobes busy=%0b want 0", t, got_q.size() - s0, busy);
      end
    end
    s0 = got_q.size(); e0 = errc_q.size();
    rand_smp();
    build(1'b0);
    send(100);
    wait_cyc(260);
    exp_cnt++;
    checks++;
    if (got_q.size() - s0 != NUM || errc_q.size() != e0 || load_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL hdr_recover: got %0d strobes %0d errs cnt %0d, want %0d strobes 0 errs cnt %0d",
                         got_q.size() - s0, errc_q.size() - e0, load_cnt, NUM, exp_cnt);
    end
  endtask

  task automatic test_len_err();
    int s0, e0, epos;
    for (int t = 0; t < 2; t++) begin
      s0 = got_q.size(); e0 = errc_q.size();
      rand_smp();
      build(1'b0);
      if (t == 0) begin
        while (fr.size() > 300) void'(fr.pop_back());
        epos = 299;
      end else begin
        fr.push_back({2'b00, 8'($urandom)});
        fr.push_back({2'b00, 8'($urandom)});
        epos = FLEN - 1;
      end
      fix_eof();
      send(100);
      wait_cyc(10);
      checks++;
      if (errc_q.size() - e0 != 1) begin
        errors++; $display("FAIL len_err_count[%0d]: got %0d want 1", t, errc_q.size() - e0);
      end else begin
        checks++;
        if (errcode_q[e0] !== 2'(model_code()) || errcode_q[e0] !== 2'd2) begin
          errors++; $display("FAIL len_code[%0d]: got %0d want 2", t, errcode_q[e0]);
        end
        checks++;
        if (errc_q[e0] != byte_cyc[epos] + 1) begin
          errors++; $display("FAIL len_err_timing[%0d]: got %0d want %0d", t, errc_q[e0], byte_cyc[epos] + 1);
        end
      end
      checks++;
      if (got_q.size() != s0) begin errors++; $display("FAIL len_strobes[%0d]: got %0d want 0", t, got_q.size() - s0); end
    end
  endtask

  task automatic test_restart();
    fw_t part[$];
    int s0, e0, nbad;
    s0 = got_q.size(); e0 = errc_q.size();
    rand_smp();
    build(1'b0);
    while (fr.size() > 100) void'(fr.pop_back());
    part = fr;
    rand_smp();
    build(1'b0);
    fr = {part, fr};
    send(100);
    wait_cyc(260);
    exp_cnt++;
    checks++;
    if (errc_q.size() - e0 != 1) begin
      errors++; $display("FAIL restart_err_count: got %0d want 1", errc_q.size() - e0);
    end else begin
      checks++;
      if (errcode_q[e0] !== 2'd2 || errc_q[e0] != byte_cyc[100] + 1) begin
        errors++; $display("FAIL restart_code: got code %0d at %0d want 2 at %0d", errcode_q[e0], errc_q[e0], byte_cyc[100] + 1);
      end
    end
    checks++;
    if (got_q.size() - s0 != NUM) begin
      errors++; $display("FAIL restart_strobes: got %0d want %0d", got_q.size() - s0, NUM);
    end else begin
      nbad = 0;
      for (int k = 0; k < NUM; k++) if (got_q[s0 + k] !== smp[k]) nbad++;
      checks++;
      if (nbad != 0) begin errors++; $display("FAIL restart_values: got %0d wrong want 0", nbad); end
    end
  endtask

  task automatic test_back_to_back();
    int s0, b0, e0, eof_b, nbad, g;
    s0 = got_q.size(); b0 = bstart_q.size(); e0 = errc_q.size();
    exp_q.delete();
    rand_smp(); push_exp(); build(1'b0);
    send(50);
    for (g = 0; g < 2000 && busy !== 1'b0; g++) wait_cyc(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_timeout: busy got %0b want 0", busy); end
    rand_smp(); push_exp(); build(1'b0);
    send(50);
    eof_b = byte_cyc[FLEN - 1];
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %0b want 1", busy); end
    rand_smp(); build(1'b0);
    send(100);
    wait_cyc(100);
    exp_cnt += 2;
    checks++;
    if (blen_q.size() - b0 != 2 || got_q.size() - s0 != 2 * NUM) begin
      errors++; $display("FAIL b2b_bursts: got %0d bursts %0d strobes want 2 bursts %0d strobes",
                         blen_q.size() - b0, got_q.size() - s0, 2 * NUM);
    end else begin
      nbad = 0;
      for (int k = 0; k < 2 * NUM; k++) if (got_q[s0 + k] !== exp_q[k]) nbad++;
      checks++;
      if (nbad != 0) begin errors++; $display("FAIL b2b_values: got %0d wrong want 0", nbad); end
      checks++;
      if (bstart_q[b0 + 1] - bend_q[b0] - 1 < 2) begin
        errors++; $display("FAIL b2b_gap: got %0d want >= 2", bstart_q[b0 + 1] - bend_q[b0] - 1);
      end
      checks++;
      if (bstart_q[b0 + 1] - eof_b != 2) begin
        errors++; $display("FAIL b2b_latency: got %0d want 2", bstart_q[b0 + 1] - eof_b);
      end
    end
    checks++;
    if (errc_q.size() != e0 || load_cnt !== 8'(exp_cnt)) begin
      errors++; $display("FAIL b2b_err_cnt: got %0d errs cnt %0d want 0 errs cnt %0d", errc_q.size() - e0, load_cnt, exp_cnt);
    end
    checks++;
    if (err_code !== 2'd2) begin errors++; $display("FAIL b2b_code_held: got %0d want 2", err_code); end
  endtask

  task automatic test_reset_mid();
    int s0, d0, g;
    s0 = got_q.size(); d0 = done_q.size();
    rand_smp(); build(1'b0);
    send(100);
    for (g = 0; g < 1000 && (got_q.size() - s0) < 57; g++) begin @(posedge clke); #2; end
    checks++;
    if (got_q.size() - s0 != 57 || opora_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_reach: got %0d strobes en=%0b want 57 en=1", got_q.size() - s0, opora_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({opora_en, OPORA, busy, load_done, load_err, err_code, load_cnt} !== 30'd0) begin
      errors++; $display("FAIL rstmid_outputs: got en=%0b opora=%h busy=%0b done=%0b err=%0b code=%0d cnt=%0d want all 0",
                         opora_en, OPORA, busy, load_done, load_err, err_code, load_cnt);
    end
    repeat (3) @(posedge clke);
    #3;
    rst = 1'b0;
    s0 = got_q.size();
    wait_cyc(300);
    checks++;
    if (got_q.size() != s0 || done_q.size() != d0 || load_cnt !== 8'd0) begin
      errors++; $display("FAIL rstmid_after: got %0d strobes %0d done cnt %0d want 0 0 0",
                         got_q.size() - s0, done_q.size() - d0, load_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_csum_err();
    test_hdr_err();
    test_len_err();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
